// File: rtl/pat_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pat_gen_pkg
//  Purpose  : Shared types and constants for the pattern frame generator.
//  Revision : 1.0 - initial release
// ============================================================================
package pat_gen_pkg;

    // Default width of each runtime geometry field
    localparam int c_CNT_WIDTH = 16;

    // Generator control states
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage
`default_nettype wire

// File: rtl/pat_frame_counter.sv
`default_nettype none
// ============================================================================
//  Module   : pat_frame_counter
//  Purpose  : Nested beat/row/frame down-counter. The geometry is captured on
//             load; every advance steps the beat counter and carries into the
//             row and frame counters, reloading each counter as it wraps.
//  Revision : 1.0 - initial release
// ============================================================================
module pat_frame_counter
    import pat_gen_pkg::*;
#(
    parameter int CNT_WIDTH = c_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load_i,
    input  logic                 advance_i,
    input  logic [CNT_WIDTH-1:0] beats_i,
    input  logic [CNT_WIDTH-1:0] rows_i,
    input  logic [CNT_WIDTH-1:0] frames_i,
    output logic                 last_beat_o,
    output logic                 first_beat_o,
    output logic                 end_frame_o,
    output logic                 end_burst_o
);

    localparam logic [CNT_WIDTH-1:0] c_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    // Counters hold "remaining minus one", so a field of 0 or 1 both give 0
    logic [CNT_WIDTH-1:0] w_beats_m1;
    logic [CNT_WIDTH-1:0] w_rows_m1;
    logic [CNT_WIDTH-1:0] w_frames_m1;

    assign w_beats_m1  = (beats_i  == '0) ? '0 : beats_i  - c_ONE;
    assign w_rows_m1   = (rows_i   == '0) ? '0 : rows_i   - c_ONE;
    assign w_frames_m1 = (frames_i == '0) ? '0 : frames_i - c_ONE;

    logic [CNT_WIDTH-1:0] r_rld_beat_q,  r_rld_beat_d;
    logic [CNT_WIDTH-1:0] r_rld_row_q,   r_rld_row_d;
    logic [CNT_WIDTH-1:0] r_rld_frame_q, r_rld_frame_d;
    logic [CNT_WIDTH-1:0] r_beat_q,      r_beat_d;
    logic [CNT_WIDTH-1:0] r_row_q,       r_row_d;
    logic [CNT_WIDTH-1:0] r_frame_q,     r_frame_d;

    // Counter and reload registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rld_beat_q  <= '0;
            r_rld_row_q   <= '0;
            r_rld_frame_q <= '0;
            r_beat_q      <= '0;
            r_row_q       <= '0;
            r_frame_q     <= '0;
        end else begin
            r_rld_beat_q  <= r_rld_beat_d;
            r_rld_row_q   <= r_rld_row_d;
            r_rld_frame_q <= r_rld_frame_d;
            r_beat_q      <= r_beat_d;
            r_row_q       <= r_row_d;
            r_frame_q     <= r_frame_d;
        end
    end

    // Load wins over advance so a back-to-back pattern starts from full counts
    always_comb begin
        r_rld_beat_d  = r_rld_beat_q;
        r_rld_row_d   = r_rld_row_q;
        r_rld_frame_d = r_rld_frame_q;
        r_beat_d      = r_beat_q;
        r_row_d       = r_row_q;
        r_frame_d     = r_frame_q;
        if (load_i) begin
            r_rld_beat_d  = w_beats_m1;
            r_rld_row_d   = w_rows_m1;
            r_rld_frame_d = w_frames_m1;
            r_beat_d      = w_beats_m1;
            r_row_d       = w_rows_m1;
            r_frame_d     = w_frames_m1;
        end else if (advance_i) begin
            if (r_beat_q != '0) begin
                r_beat_d = r_beat_q - c_ONE;
            end else begin
                r_beat_d = r_rld_beat_q;
                if (r_row_q != '0) begin
                    r_row_d = r_row_q - c_ONE;
                end else begin
                    r_row_d = r_rld_row_q;
                    if (r_frame_q != '0) begin
                        r_frame_d = r_frame_q - c_ONE;
                    end else begin
                        r_frame_d = r_rld_frame_q;
                    end
                end
            end
        end
    end

    assign last_beat_o  = (r_beat_q == '0);
    assign first_beat_o = (r_beat_q == r_rld_beat_q) && (r_row_q == r_rld_row_q);
    assign end_frame_o  = last_beat_o && (r_row_q == '0);
    assign end_burst_o  = end_frame_o && (r_frame_q == '0);

endmodule
`default_nettype wire

// File: rtl/pat_frame_gen.sv
`default_nettype none
// ============================================================================
//  Module   : pat_frame_gen
//  Purpose  : Accepts a pattern word on an AXI-Stream input and emits it,
//             replicated across the output bus, as a burst of frames with
//             runtime-configurable beats/row, rows/frame and frames/burst.
//  Revision : 1.0 - initial release
// ============================================================================
module pat_frame_gen
    import pat_gen_pkg::*;
#(
    parameter int PATTERN_WIDTH = 32,
    parameter int OUTPUT_WIDTH  = 512,
    parameter int CNT_WIDTH     = c_CNT_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [CNT_WIDTH-1:0]     cfg_cycles_per_row,
    input  logic [CNT_WIDTH-1:0]     cfg_rows_per_frame,
    input  logic [CNT_WIDTH-1:0]     cfg_frames_per_pattern,
    input  logic                     cfg_continuous,
    input  logic [PATTERN_WIDTH-1:0] AXIS_IN_TDATA,
    input  logic                     AXIS_IN_TVALID,
    output logic                     AXIS_IN_TREADY,
    output logic [OUTPUT_WIDTH-1:0]  AXIS_OUT_TDATA,
    output logic                     AXIS_OUT_TVALID,
    output logic                     AXIS_OUT_TLAST,
    output logic                     AXIS_OUT_TUSER,
    input  logic                     AXIS_OUT_TREADY,
    output logic [31:0]              frame_count,
    output logic                     idle
);

    localparam int c_REPS = OUTPUT_WIDTH / PATTERN_WIDTH;
    localparam int c_PAD  = OUTPUT_WIDTH - c_REPS * PATTERN_WIDTH;

    state_e                   r_state_q, r_state_d;
    logic [PATTERN_WIDTH-1:0] r_pattern_q;
    logic                     r_cont_q;
    logic [31:0]              r_frame_count_q;

    logic w_out_hs;
    logic w_in_hs;
    logic w_end_hs;
    logic w_last_beat;
    logic w_first_beat;
    logic w_end_frame;
    logic w_end_burst;

    assign w_out_hs = (r_state_q == RUN) && AXIS_OUT_TREADY;
    assign w_end_hs = w_out_hs && w_end_burst;
    assign w_in_hs  = AXIS_IN_TVALID && AXIS_IN_TREADY;

    pat_frame_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_counter (
        .clk          (clk),
        .reset        (reset),
        .load_i       (w_in_hs),
        .advance_i    (w_out_hs),
        .beats_i      (cfg_cycles_per_row),
        .rows_i       (cfg_rows_per_frame),
        .frames_i     (cfg_frames_per_pattern),
        .last_beat_o  (w_last_beat),
        .first_beat_o (w_first_beat),
        .end_frame_o  (w_end_frame),
        .end_burst_o  (w_end_burst)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q <= IDLE;
        end else begin
            r_state_q <= r_state_d;
        end
    end

    // Next state: leave RUN only at end of burst with no follow-on pattern
    always_comb begin
        r_state_d = r_state_q;
        case (r_state_q)
            IDLE: if (w_in_hs) r_state_d = RUN;
            RUN:  if (w_end_hs && !w_in_hs && !r_cont_q) r_state_d = IDLE;
            default: r_state_d = IDLE;
        endcase
    end

    // State outputs; input ready in RUN opens only on the final handshake
    always_comb begin
        AXIS_OUT_TVALID = 1'b0;
        AXIS_IN_TREADY  = 1'b0;
        idle            = 1'b0;
        case (r_state_q)
            IDLE: begin
                AXIS_IN_TREADY = !reset;
                idle           = 1'b1;
            end
            RUN: begin
                AXIS_OUT_TVALID = 1'b1;
                AXIS_IN_TREADY  = !reset && w_end_hs;
            end
            default: ;
        endcase
    end

    // Pattern/mode capture and completed-frame counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pattern_q     <= '0;
            r_cont_q        <= 1'b0;
            r_frame_count_q <= '0;
        end else begin
            if (w_in_hs) begin
                r_pattern_q <= AXIS_IN_TDATA;
                r_cont_q    <= cfg_continuous;
            end
            if (w_out_hs && w_end_frame) begin
                r_frame_count_q <= r_frame_count_q + 32'd1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < c_REPS; gi++) begin : g_rep
            assign AXIS_OUT_TDATA[gi*PATTERN_WIDTH +: PATTERN_WIDTH] = r_pattern_q;
        end
        if (c_PAD > 0) begin : g_pad
            assign AXIS_OUT_TDATA[OUTPUT_WIDTH-1 -: c_PAD] = '0;
        end
    endgenerate

    assign AXIS_OUT_TLAST = w_last_beat;
    assign AXIS_OUT_TUSER = w_first_beat;
    assign frame_count    = r_frame_count_q;

endmodule
`default_nettype wire

// File: doc/pat_frame_gen.md
PAT_FRAME_GEN -- requirements
Module: pat_frame_gen

Interface
REQ-001 The module SHALL have parameter PATTERN_WIDTH, default 32, giving the input pattern width in bits.
REQ-002 The module SHALL have parameter OUTPUT_WIDTH, default 512, giving the output bus width in bits; it must be at least PATTERN_WIDTH.
REQ-003 The module SHALL have parameter CNT_WIDTH, default 16, giving the width of each runtime geometry field.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all logic is synchronous to its rising edge.
REQ-005 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The module SHALL have ports cfg_cycles_per_row, cfg_rows_per_frame and cfg_frames_per_pattern, each an input of CNT_WIDTH bits: runtime frame geometry.
REQ-007 The module SHALL have port cfg_continuous, input, 1 bit: when 1, the current pattern repeats indefinitely until a new pattern arrives.
REQ-008 The module SHALL have ports AXIS_IN_TDATA (input, PATTERN_WIDTH), AXIS_IN_TVALID (input, 1) and AXIS_IN_TREADY (output, 1): the pattern input stream.
REQ-009 The module SHALL have ports AXIS_OUT_TDATA (output, OUTPUT_WIDTH), AXIS_OUT_TVALID, AXIS_OUT_TLAST and AXIS_OUT_TUSER (outputs, 1 each), and AXIS_OUT_TREADY (input, 1): the frame output stream.
REQ-010 The module SHALL have port frame_count, output, 32 bits: count of completed frames.
REQ-011 The module SHALL have port idle, output, 1 bit: high while in state IDLE.

Function
REQ-012 AXIS_OUT_TDATA SHALL be the latched pattern replicated floor(OUTPUT_WIDTH/PATTERN_WIDTH) times from bit 0 upward; any remaining upper bits are 0.
REQ-013 The state machine SHALL have two states: IDLE and RUN.
REQ-014 In IDLE, AXIS_IN_TREADY SHALL be 1 and AXIS_OUT_TVALID 0; an input handshake latches the pattern and all cfg_* inputs, loads the counters, and moves to RUN with AXIS_OUT_TVALID=1 on the next cycle.
REQ-015 The cfg_* inputs SHALL be sampled only when a pattern is loaded; changes at any other time have no effect on a burst in progress.
REQ-016 A geometry field value N SHALL mean N beats/rows/frames; a value of 0 is treated as 1.
REQ-017 In RUN, each output handshake (TVALID & TREADY) SHALL advance the nested down-counters in order beat, then row, then frame, reloading each inner counter when it wraps.
REQ-018 AXIS_OUT_TLAST SHALL be 1 on the last beat of every row.
REQ-019 AXIS_OUT_TUSER SHALL be 1 on the first beat of every frame.
REQ-020 frame_count SHALL increment by 1 on the handshake of the last beat of each frame and wrap from 2^32-1 to 0.
REQ-021 In RUN, AXIS_IN_TREADY SHALL be 1 only during the handshake of the last beat of the last frame of a burst (a combinational path from AXIS_OUT_TREADY).
REQ-022 At end of burst with an input handshake, the new pattern and cfg SHALL load with no bubble: the next output beat carries the new pattern with TUSER=1.
REQ-023 At end of burst with no input handshake and cfg_continuous=0 (latched), the block SHALL return to IDLE with TVALID=0 on the next cycle.
REQ-024 At end of burst with no input handshake and cfg_continuous=1 (latched), the block SHALL restart the same pattern and geometry with no bubble.
REQ-025 While TVALID=1 and TREADY=0, TDATA, TLAST and TUSER SHALL remain stable.

Reset
REQ-026 While reset=1, AXIS_IN_TREADY SHALL be 0, even combinationally.
REQ-027 On a clock edge with reset=1, the block SHALL enter IDLE and set AXIS_OUT_TVALID=0, pattern=0, all counters=0 and frame_count=0.
REQ-028 A reset during a burst SHALL abort it immediately; no TLAST is produced for the truncated row.

Structure
REQ-029 A shared package pat_gen_pkg SHALL hold the state enumeration (IDLE, RUN) and the default CNT_WIDTH constant.
REQ-030 The nested beat/row/frame down-counter, with its load, advance and end-of-row/frame/burst flags, SHALL be a sub-module named pat_frame_counter.

Verification
REQ-031 Geometry 4/3/1, cont=0, pattern 0xA5A5A5A5, TREADY=1 -> 12 beats; TLAST on beats 4, 8 and 12; TUSER on beat 1; frame_count=1; then idle=1.
REQ-032 Second pattern 0x12345678 held valid throughout the first burst -> beat 13 carries 0x12345678 with TUSER=1; no TVALID gap.
REQ-033 Geometry 2/2/3, cont=1, one pattern, run 40 beats -> TUSER every 4 beats and frame_count=10; cfg changed mid-burst has no effect.
REQ-034 Random TREADY (50%) with geometry 4/3/1 -> exactly 12 handshakes and TDATA/TLAST stable while stalled.
REQ-035 Geometry 0/0/0 -> a single beat with TLAST=1 and TUSER=1.
REQ-036 Reset asserted at beat 5 -> TVALID=0 on the next cycle and frame_count=0; a new pattern afterwards starts cleanly with TUSER=1.
